paddle_bank_ctrl: RTL and testbench
===================================

// Module: paddle_bank_ctrl
// PURPOSE
// - Parametrised N-player paddle position controller for the arcade Pong path.
// - Consumes decoded PS/2 scan-code bytes from the keyboard decoder and tracks a
//   held/released state for every player's UP/DOWN key, including F0 break and
//   E0 extended prefixes with a prefix timeout.
// - On each motion tick, moves each paddle by a step and clamps it to the playfield
//   frame. Outputs feed the VGA renderer and the ball collision logic.
// PARAMETERS
// N_PLAYERS      2         number of paddles, 1..8
// UP_KEYS        16'h441D  packed 8-bit make codes; player i = bits [8i+7:8i] (W, O)
// DOWN_KEYS      16'h4B1B  packed 8-bit make codes (S, L)
// SCREEN_HEIGHT  480       playfield height in pixels
// PADDLE_LENGTH  40        paddle length in pixels
// FRAME_WIDTH    10        border size; top clamp value
// MOTION_STEP    10        pixels moved per tick
// TICK_COUNT     12500000  clk cycles per motion tick (250 ms at 50 MHz)
// PREFIX_TIMEOUT 65536     cycles before a pending F0/E0 prefix is discarded
// ACCEL_TICKS    4         consecutive held ticks before fast step (accel build only)
// Derived: PW = clog2(SCREEN_HEIGHT); START_POS = (SCREEN_HEIGHT-PADDLE_LENGTH)/2;
//          BOTTOM_POS = SCREEN_HEIGHT-PADDLE_LENGTH-FRAME_WIDTH
// PORTS
// clk     in   1          system clock, 50 MHz
// rst     in   1          asynchronous reset, active-high
// code    in   8          scan-code byte from the PS/2 decoder
// valid   in   1          level; a new byte is accepted on each rising edge only
// pos     out  N*PW       paddle top positions; player i = [PW*i+PW-1:PW*i]
// held    out  2*N        key state; bit 2i = UP held, bit 2i+1 = DOWN held
// tick    out  1          one-cycle pulse on each motion tick
// BEHAVIOUR
// - Reset (async, rst=1): pos all START_POS; held 0; tick 0; tick counter 0;
//   FSM IDLE; prefix flags clear.
// - Byte strobe: valid_q is registered. byte_en = valid & ~valid_q. A valid held high
//   for many cycles gives exactly one byte.
// - Key FSM, per byte_en:
//   - IDLE: E0 -> EXT; F0 -> BRK; otherwise make event for the code.
//   - BRK: break event for the code -> IDLE.
//   - EXT: F0 -> EXT_BRK; otherwise the byte is consumed and ignored -> IDLE.
//   - EXT_BRK: byte ignored -> IDLE.
//   - Extended keys never match UP_KEYS/DOWN_KEYS.
// - Prefix timeout: any non-IDLE state with no byte_en for PREFIX_TIMEOUT cycles
//   -> IDLE. The counter restarts on every byte_en.
// - Events: a make sets, and a break clears, every held bit whose key code matches.
//   Duplicate codes across players are legal; all matches update. Typematic
//   repeats are idempotent. Unmatched codes have no effect.
// - Tick: counter 0..TICK_COUNT-1. tick=1 in the cycle the counter wraps.
// - Motion on tick, using held as registered before that cycle's key update:
//   - DOWN only: pos = min(pos+step, BOTTOM_POS).
//   - UP only: pos = max(pos-step, FRAME_WIDTH). Saturates; never refuses a move.
//   - Both or neither held: no change.
// - Arithmetic: compute in PW+1 bits signed so that pos-step < 0 clamps correctly.
// - Output latency: pos updates the cycle after tick; held updates the cycle after byte_en.
// CONFIGURATION
// - `PADDLE_ACCEL_EN defined:
//   - Each player has a saturating hold counter, incremented per tick while exactly one
//     direction is held. It clears on release, on a direction change, or on both keys held.
//   - Once the counter reaches ACCEL_TICKS, step = 2*MOTION_STEP; clamping is unchanged.
// - Undefined: step is always MOTION_STEP and no hold counters are built.
// STRUCTURE
// - paddle_pkg: BREAK_CODE=8'hF0, EXT_CODE=8'hE0, FSM state encodings
//   (IDLE/BRK/EXT/EXT_BRK), clog2 function.
// - Sub-module ps2_key_tracker: strobe edge detect, FSM, timeout. Outputs make_pulse,
//   brk_pulse and key[7:0].
// - Top: key match, held regs, tick counter, generate loop of N motion/clamp slices.
// TESTING (bench overrides TICK_COUNT=16, PREFIX_TIMEOUT=32)
// - Reset: pulse rst -> pos = {220,220}, held = 0, no tick during rst.
// - Move and release: byte 1B, then 3 ticks -> pos0 = 250. Bytes F0 1B -> held[1]=0;
//   pos0 stays 250 on later ticks.
// - Clamp: pos0 at 425 with DOWN held -> 430 next tick, stays 430. pos1 at 15 with UP
//   held -> 10 and stays.
// - Conflict and strobe: hold 1D and 1B -> no motion. Byte F0 1D -> pos0 +10 per tick.
//   A valid high for 5 cycles with 44 -> exactly one make.
// - Prefix: E0 1B -> held unchanged. E0 F0 1B -> unchanged. F0 then 40 idle cycles,
//   then 1B -> treated as make (held[1]=1).
// - Async reset and accel: assert rst mid-tick while moving -> pos=220 without a clk
//   edge. With `PADDLE_ACCEL_EN: hold 1B for 6 ticks from 220 ->
//   230,240,250,260,280,300.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared constants for the paddle controller: PS/2 prefix codes, key FSM state
// encodings and a constant-evaluable clog2.
package paddle_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/paddle_bank_ctrl_if.sv
// Scan-code byte channel from the PS/2 decoder into the paddle controller.
interface paddle_bank_ctrl_if;
    logic [7:0] code;
    logic       valid;

    modport master (output code, output valid);
    modport slave  (input  code, input  valid);
endinterface

// File: rtl/paddle_bank_ctrl_tracker.sv
// PS/2 byte strobe, F0/E0 prefix FSM with timeout; emits one-cycle make/break
// pulses alongside the key byte.
module ps2_key_tracker
    import paddle_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 65536
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       valid,
    output logic       make_pulse,
    output logic       brk_pulse,
    output logic [7:0] key
);

    localparam int unsigned TW = clog2(PREFIX_TIMEOUT) + 1;

    logic          valid_q, valid_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_en;

    assign key = code;

    always_comb begin
        valid_d    = valid;
        byte_en    = valid & ~valid_q;
        state_d    = state_q;
        tmo_d      = tmo_q;
        make_pulse = 1'b0;
        brk_pulse  = 1'b0;
        if (byte_en) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (code == EXT_CODE)
                        state_d = ST_EXT;
                    else if (code == BREAK_CODE)
                        state_d = ST_BRK;
                    else
                        make_pulse = 1'b1;
                end
                ST_BRK: begin
                    brk_pulse = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_EXT:  state_d = (code == BREAK_CODE) ? ST_EXT_BRK : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TW'(PREFIX_TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
            tmo_q   <= '0;
        end else begin
            valid_q <= valid_d;
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: rtl/paddle_bank_ctrl.sv
// N-player paddle controller: key held state, motion tick and clamped paddle motion.
// Optional hold-to-accelerate step is built when PADDLE_ACCEL_EN is defined.
module paddle_bank_ctrl
    import paddle_pkg::*;
#(
    parameter int unsigned             N_PLAYERS      = 2,
    parameter logic [8*N_PLAYERS-1:0]  UP_KEYS        = 16'h441D,
    parameter logic [8*N_PLAYERS-1:0]  DOWN_KEYS      = 16'h4B1B,
    parameter int unsigned             SCREEN_HEIGHT  = 480,
    parameter int unsigned             PADDLE_LENGTH  = 40,
    parameter int unsigned             FRAME_WIDTH    = 10,
    parameter int unsigned             MOTION_STEP    = 10,
    parameter int unsigned             TICK_COUNT     = 12500000,
    parameter int unsigned             PREFIX_TIMEOUT = 65536,
    parameter int unsigned             ACCEL_TICKS    = 4,
    localparam int unsigned            PW             = clog2(SCREEN_HEIGHT)
)(
    input  logic                    clk,
    input  logic                    rst,
    paddle_bank_ctrl_if.slave       kbd,
    output logic [N_PLAYERS*PW-1:0] pos,
    output logic [2*N_PLAYERS-1:0]  held,
    output logic                    tick
);

    localparam int unsigned TCW = clog2(TICK_COUNT) + 1;
    localparam int unsigned PW1 = PW + 1;

    localparam logic [PW-1:0]        START_U  = PW'((SCREEN_HEIGHT - PADDLE_LENGTH) / 2);
    localparam logic [PW-1:0]        BOTTOM_U = PW'(SCREEN_HEIGHT - PADDLE_LENGTH - FRAME_WIDTH);
    localparam logic [PW-1:0]        TOP_U    = PW'(FRAME_WIDTH);
    localparam logic signed [PW:0]   BOTTOM_S = $signed(PW1'(SCREEN_HEIGHT - PADDLE_LENGTH - FRAME_WIDTH));
    localparam logic signed [PW:0]   TOP_S    = $signed(PW1'(FRAME_WIDTH));
    localparam logic signed [PW:0]   STEP_N   = $signed(PW1'(MOTION_STEP));

    logic       make_pulse, brk_pulse;
    logic [7:0] key;

    ps2_key_tracker #(
        .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .code      (kbd.code),
        .valid     (kbd.valid),
        .make_pulse(make_pulse),
        .brk_pulse (brk_pulse),
        .key       (key)
    );

    logic [2*N_PLAYERS-1:0] held_q, held_d;
    logic [TCW-1:0]         cnt_q, cnt_d;

    assign held = held_q;
    assign tick = (cnt_q == TCW'(TICK_COUNT - 1));

    always_comb begin
        held_d = held_q;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            if (key == UP_KEYS[8*i +: 8]) begin
                if (make_pulse) held_d[2*i] = 1'b1;
                if (brk_pulse)  held_d[2*i] = 1'b0;
            end
            if (key == DOWN_KEYS[8*i +: 8]) begin
                if (make_pulse) held_d[2*i+1] = 1'b1;
                if (brk_pulse)  held_d[2*i+1] = 1'b0;
            end
        end
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
            cnt_q  <= '0;
        end else begin
            held_q <= held_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_slice
        logic                 up, dn;
        logic [PW-1:0]        pos_q, pos_d;
        logic signed [PW:0]   step_s, up_val, dn_val;

        // Motion reads held_q, so a key event in the tick cycle affects the next tick.
        assign up = held_q[2*g];
        assign dn = held_q[2*g+1];

`ifdef PADDLE_ACCEL_EN
        localparam int unsigned AW = clog2(ACCEL_TICKS) + 1;
        logic [AW-1:0] hold_q, hold_d;

        always_comb begin
            hold_d = hold_q;
            if (!(up ^ dn))
                hold_d = '0;
            else if (tick && (hold_q < AW'(ACCEL_TICKS)))
                hold_d = hold_q + 1'b1;
            step_s = (hold_q >= AW'(ACCEL_TICKS)) ? (STEP_N <<< 1) : STEP_N;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) hold_q <= '0;
            else     hold_q <= hold_d;
        end
`else
        always_comb step_s = STEP_N;
`endif

        always_comb begin
            pos_d  = pos_q;
            dn_val = $signed({1'b0, pos_q}) + step_s;
            up_val = $signed({1'b0, pos_q}) - step_s;
            if (tick) begin
                if (dn && !up)
                    pos_d = (dn_val > BOTTOM_S) ? BOTTOM_U : dn_val[PW-1:0];
                else if (up && !dn)
                    pos_d = (up_val < TOP_S) ? TOP_U : up_val[PW-1:0];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) pos_q <= START_U;
            else     pos_q <= pos_d;
        end

        assign pos[PW*g +: PW] = pos_q;
    end

endmodule

// File: tb/tb_paddle_bank_ctrl.sv
// Randomised and directed checks of paddle_bank_ctrl against a key-event level model.
module tb_paddle_bank_ctrl;

    localparam int N  = 2;
    localparam int PW = 9;
    localparam int TC = 16;
    localparam int PT = 32;
    localparam int STEP = 10, TOPV = 10, BOTV = 430, STARTV = 220, ACC_T = 4;
`ifdef PADDLE_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [N*PW-1:0] pos;
    logic [2*N-1:0]  held;
    logic            tick;

    always #5 clk = ~clk;

    paddle_bank_ctrl_if kbd ();

    paddle_bank_ctrl #(
        .TICK_COUNT    (TC),
        .PREFIX_TIMEOUT(PT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kbd (kbd),
        .pos (pos),
        .held(held),
        .tick(tick)
    );

    logic [7:0] up_key [N] = '{8'h1D, 8'h44};
    logic [7:0] dn_key [N] = '{8'h1B, 8'h4B};

    int n_vec = 0;
    int n_bad = 0;

    // Model state: key booleans, pending prefix flags, cycle counts.
    int m_pos  [N];
    bit m_up   [N];
    bit m_dn   [N];
    int m_hold [N];
    int m_cnt;
    bit m_vprev;
    bit pend_brk, pend_ext;
    int pend_quiet;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pos[i] = STARTV; m_up[i] = 0; m_dn[i] = 0; m_hold[i] = 0;
        end
        m_cnt = 0; m_vprev = 0;
        pend_brk = 0; pend_ext = 0; pend_quiet = 0;
    endtask

    function automatic int model_held();
        int h = 0;
        for (int i = 0; i < N; i++)
            h |= (int'(m_up[i]) << (2*i)) | (int'(m_dn[i]) << (2*i+1));
        return h;
    endfunction

    task automatic key_event(input logic [7:0] c, input bit make);
        for (int i = 0; i < N; i++) begin
            if (c == up_key[i]) m_up[i] = make;
            if (c == dn_key[i]) m_dn[i] = make;
        end
    endtask

    task automatic model_byte(input logic [7:0] c);
        pend_quiet = 0;
        if (pend_ext) begin
            if (c == 8'hF0 && !pend_brk) pend_brk = 1;
            else begin pend_ext = 0; pend_brk = 0; end
        end else if (pend_brk) begin
            key_event(c, 0);
            pend_brk = 0;
        end else if (c == 8'hE0) pend_ext = 1;
        else if (c == 8'hF0) pend_brk = 1;
        else key_event(c, 1);
    endtask

    task automatic model_edge();
        bit be, tk;
        int st;
        if (rst) begin model_reset(); return; end
        be = kbd.valid && !m_vprev;
        m_vprev = kbd.valid;
        tk = (m_cnt == TC-1);
        for (int i = 0; i < N; i++) begin
            st = (ACCEL && m_hold[i] >= ACC_T) ? 2*STEP : STEP;
            if (tk && m_dn[i] && !m_up[i]) m_pos[i] = (m_pos[i] + st > BOTV) ? BOTV : m_pos[i] + st;
            if (tk && m_up[i] && !m_dn[i]) m_pos[i] = (m_pos[i] - st < TOPV) ? TOPV : m_pos[i] - st;
            if (m_up[i] == m_dn[i]) m_hold[i] = 0;
            else if (tk && m_hold[i] < ACC_T) m_hold[i]++;
        end
        if (be) model_byte(kbd.code);
        else if (pend_brk || pend_ext) begin
            pend_quiet++;
            if (pend_quiet == PT) begin pend_brk = 0; pend_ext = 0; end
        end
        m_cnt = (m_cnt + 1) % TC;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        for (int i = 0; i < N; i++)
            check_val($sformatf("pos%0d", i), int'(pos[i*PW +: PW]), m_pos[i]);
        check_val("held", int'(held), model_held());
        check_val("tick", int'(tick), int'(m_cnt == TC-1));
    endtask

    task automatic send(input logic [7:0] c, input int hi = 1, input int lo = 1);
        kbd.code  = c;
        kbd.valid = 1'b1;
        repeat (hi) step();
        kbd.valid = 1'b0;
        repeat (lo) step();
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int lim  = n*TC*2 + 4;
        while (seen < n && lim > 0) begin
            step();
            if (tick) seen++;
            lim--;
        end
        check_val("tick_wait", seen, n);
        step();
    endtask

    int accel_exp [6];
    int p0;

    initial begin
        rst = 1'b1; kbd.valid = 1'b0; kbd.code = 8'h00;
        model_reset();
        #2;
        repeat (3) step();
        check_val("rst_pos0", int'(pos[PW-1:0]), STARTV);
        check_val("rst_pos1", int'(pos[2*PW-1:PW]), STARTV);
        rst = 1'b0;
        step();

        // Move down and release
        send(8'h1B);
        wait_ticks(3);
        check_val("move_250", int'(pos[PW-1:0]), 250);
        send(8'hF0); send(8'h1B);
        check_val("release_held", int'(held), 0);
        wait_ticks(2);
        check_val("release_stay", int'(pos[PW-1:0]), 250);

        // Both keys held, then release UP
        send(8'h1B); send(8'h1D);
        wait_ticks(2);
        check_val("conflict_stay", int'(pos[PW-1:0]), 250);
        send(8'hF0); send(8'h1D);
        wait_ticks(1);
        check_val("conflict_release", int'(pos[PW-1:0]), 260);

        // Clamps
        wait_ticks(30);
        check_val("clamp_bottom", int'(pos[PW-1:0]), BOTV);
        send(8'h44);
        wait_ticks(30);
        check_val("clamp_top", int'(pos[2*PW-1:PW]), TOPV);
        send(8'hF0); send(8'h1B); send(8'hF0); send(8'h44);

        // Level valid gives one byte
        send(8'h44, 5, 2);
        check_val("strobe_make", int'(held), 4'b0100);
        send(8'hF0); send(8'h44);
        send(8'hE0, 5, 2); send(8'h1B);
        check_val("strobe_ext", int'(held), 0);

        // Prefixes
        send(8'hE0); send(8'h1B);
        check_val("ext_make", int'(held), 0);
        send(8'hE0); send(8'hF0); send(8'h1B);
        check_val("ext_break", int'(held), 0);
        send(8'hF0, 1, 40); send(8'h1B);
        check_val("prefix_timeout", int'(held), 4'b0010);

        // Async reset mid-cycle
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check_val("async_pos0", int'(pos[PW-1:0]), STARTV);
        check_val("async_pos1", int'(pos[2*PW-1:PW]), STARTV);
        check_val("async_held", int'(held), 0);
        check_val("async_tick", int'(tick), 0);
        model_reset();
        repeat (2) step();
        rst = 1'b0;

        // Per-tick trajectory from START with DOWN held
        accel_exp = ACCEL ? '{230, 240, 250, 260, 280, 300} : '{230, 240, 250, 260, 270, 280};
        send(8'h1B);
        for (int k = 0; k < 6; k++) begin
            wait_ticks(1);
            check_val($sformatf("traj%0d", k), int'(pos[PW-1:0]), accel_exp[k]);
        end

        // Random byte stream
        for (int it = 0; it < 300; it++) begin
            logic [7:0] c;
            case ($urandom_range(0, 7))
                0: c = 8'h1D; 1: c = 8'h1B; 2: c = 8'h44; 3: c = 8'h4B;
                4, 5: c = 8'hF0; 6: c = 8'hE0;
                default: c = 8'($urandom);
            endcase
            send(c, $urandom_range(1, 4), ($urandom_range(0, 15) == 0) ? $urandom_range(28, 40) : $urandom_range(1, 6));
        end

        p0 = int'(pos[PW-1:0]);
        check_val("pos0_range", int'(p0 >= TOPV && p0 <= BOTV), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
